misaligned_load_unit: RTL
=========================

MISALIGNED_LOAD_UNIT -- requirements
Module: misaligned_load_unit

Interface
REQ-001 Parameter XLEN, 32, data width in bits; legal values 32 and 64.
REQ-002 Parameter ALLOW_MISALIGNED, 1, 1 = split boundary-crossing loads into two beats, 0 = raise fault.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  1  load request present.
REQ-006 req_ready  out  1  unit idle and accepting a request.
REQ-007 req_addr  in  32  byte address of load.
REQ-008 req_funct3  in  3  RISC-V load funct3: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
REQ-009 mem_valid  out  1  memory read beat requested.
REQ-010 mem_ready  in  1  memory beat complete; mem_rdata valid this cycle.
REQ-011 mem_addr  out  32  beat address, aligned to XLEN/8 bytes.
REQ-012 mem_rdata  in  XLEN  beat read data, little-endian.
REQ-013 rsp_valid  out  1  result available.
REQ-014 rsp_ready  in  1  consumer takes result.
REQ-015 rsp_data  out  XLEN  aligned, sign/zero-extended load result.
REQ-016 rsp_fault  out  1  misaligned (ALLOW_MISALIGNED=0) or illegal funct3.

Function
REQ-017 B = XLEN/8; off = req_addr[log2(B)-1:0]; size = 1 << funct3[1:0]; cross = (off + size > B).
REQ-018 Illegal funct3: 111 always; 011 and 110 when XLEN=32.
REQ-019 FSM states IDLE, BEAT0, BEAT1, RESP; req_ready = 1 only in IDLE.
REQ-020 IDLE: on req_valid, latch addr/funct3/off/cross; illegal or (cross and ALLOW_MISALIGNED=0) -> RESP with rsp_fault=1, rsp_data=0, no memory beat; else -> BEAT0.
REQ-021 BEAT0: mem_valid=1, mem_addr = addr with low log2(B) bits cleared; on mem_ready, capture mem_rdata; -> BEAT1 if cross, else -> RESP.
REQ-022 BEAT1: mem_valid=1, mem_addr = BEAT0 address + B, modulo 2^32 (0xFFFFFFFC + 4 wraps to 0x00000000); on mem_ready -> RESP.
REQ-023 mem_valid and mem_addr held stable until mem_ready; mem_valid never asserted in IDLE or RESP.
REQ-024 Assembly: result byte i = beat0 byte (off+i) if off+i < B, else beat1 byte (off+i-B).
REQ-025 Extension: funct3[2]=0 sign-extends from bit 8*size-1 to XLEN; funct3[2]=1 zero-extends; size = B returns the assembled bytes unchanged.
REQ-026 rsp_data and rsp_fault are registered; rsp_valid=1 throughout RESP; all three held stable while rsp_ready=0.
REQ-027 RESP: on rsp_ready -> IDLE; a new request is not accepted in the same cycle.
REQ-028 Latency, with acceptance at edge N and mem_ready=1 immediately: aligned rsp_valid from cycle N+2; crossing from N+3; fault from N+1.
REQ-029 Memory wait states extend BEAT0/BEAT1 one cycle per cycle with mem_ready=0.

Reset
REQ-030 resetn=0 at a rising edge -> state IDLE; req_ready=1, mem_valid=0, rsp_valid=0, rsp_fault=0, rsp_data=0, mem_addr=0.
REQ-031 Reset mid-operation in any state aborts the access; a late mem_ready is ignored; no response is produced.

Verification
REQ-032 XLEN=32, LW 0x100, mem_rdata 0xDEADBEEF, mem_ready=1 -> one beat at 0x100, rsp_data 0xDEADBEEF at N+2.
REQ-033 LH 0x103, beat0 0x100 returns 0x80AABBCC, beat1 0x104 returns 0x112233FF -> rsp_data 0xFFFFFF80 at N+3; repeat as LHU -> 0x0000FF80.
REQ-034 LB 0x102, rdata 0x00800000 -> 0xFFFFFF80; LBU -> 0x00000080; LW 0xFFFFFFFE -> beats at 0xFFFFFFFC then 0x00000000.
REQ-035 ALLOW_MISALIGNED=0, LW 0x101 -> mem_valid never 1, rsp_valid at N+1 with rsp_fault=1, rsp_data=0; funct3=111 -> same fault.
REQ-036 rsp_ready=0 for 3 cycles in RESP -> rsp_data stable, req_ready=0; resetn=0 during BEAT1 -> next cycle mem_valid=0, rsp_valid=0, req_ready=1.
REQ-037 XLEN=64, LD 0x1004, beat0 0x1000 returns 0x8877665544332211, beat1 0x1008 returns 0x00000000AABBCCDD -> rsp_data 0xAABBCCDD88776655.

Source files
------------

// File: rtl/misaligned_load_unit.sv
// RISC-V load unit: fetches one or two aligned memory beats, stitches the
// addressed bytes together and sign/zero-extends the result.
module misaligned_load_unit #(
  parameter int unsigned XLEN             = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [31:0]     mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault
);

  localparam int unsigned B    = XLEN / 8;
  localparam int unsigned OffW = $clog2(B);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

  state_e            state_q, state_d;
  logic [31:0]       base_q;
  logic [2:0]        funct3_q;
  logic [OffW-1:0]   off_q;
  logic              cross_q;
  logic [XLEN-1:0]   beat0_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              rsp_fault_q;

  logic [4:0]        span;
  logic              req_cross;
  logic              req_illegal;
  logic              req_fault;
  logic [XLEN-1:0]   lo_beat;
  logic [XLEN-1:0]   asm_data;
  logic [XLEN-1:0]   keep;
  logic              sbit;
  logic [XLEN-1:0]   ext_data;

  // Request decode, evaluated against the live request in IDLE.
  always_comb begin
    span        = 5'(req_addr[OffW-1:0]) + (5'd1 << req_funct3[1:0]);
    req_cross   = span > 5'(B);
    req_illegal = (req_funct3 == 3'b111) ||
                  ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    req_fault   = req_illegal || (req_cross && !ALLOW_MISALIGNED);
  end

  // Byte assembly: {beat1, beat0} shifted down by the byte offset. For a
  // single-beat load the upper half is don't-care and masked by extension.
  always_comb begin
    lo_beat  = (state_q == StBeat0) ? mem_rdata : beat0_q;
    asm_data = XLEN'({mem_rdata, lo_beat} >> {off_q, 3'b000});
    keep     = ~({XLEN{1'b1}} << (8 << funct3_q[1:0]));
    unique case (funct3_q[1:0])
      2'b00:   sbit = asm_data[7];
      2'b01:   sbit = asm_data[15];
      2'b10:   sbit = asm_data[31];
      default: sbit = asm_data[XLEN-1];
    endcase
    ext_data = (!funct3_q[2] && sbit) ? (asm_data | ~keep) : (asm_data & keep);
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_fault ? StResp : StBeat0;
      end
      StBeat0: begin
        mem_valid = 1'b1;
        mem_addr  = base_q;
        if (mem_ready) state_d = cross_q ? StBeat1 : StResp;
      end
      StBeat1: begin
        mem_valid = 1'b1;
        mem_addr  = base_q + 32'(B);
        if (mem_ready) state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      base_q      <= 32'h0;
      funct3_q    <= 3'b000;
      off_q       <= '0;
      cross_q     <= 1'b0;
      beat0_q     <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        base_q      <= {req_addr[31:OffW], {OffW{1'b0}}};
        funct3_q    <= req_funct3;
        off_q       <= req_addr[OffW-1:0];
        cross_q     <= req_cross;
        rsp_fault_q <= req_fault;
        if (req_fault) rsp_data_q <= '0;
      end
      if (state_q == StBeat0 && mem_ready) begin
        beat0_q <= mem_rdata;
        if (!cross_q) rsp_data_q <= ext_data;
      end
      if (state_q == StBeat1 && mem_ready) rsp_data_q <= ext_data;
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

endmodule
